// File: rtl/free_list_mw.sv
// free_list_mw: multi-way physical register free list for rename,
// with head-pointer checkpoints for one-cycle mispredict recovery.
module free_list_mw #(
    parameter int P_REGISTERS = 64,
    parameter int L_REGISTERS = 32,
    parameter int WIDTH       = 2,
    parameter int C_NUM       = 4,
    localparam int PW = $clog2(P_REGISTERS),
    localparam int CW = $clog2(C_NUM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    alloc_req,
    output logic                alloc_ready,
    output logic [WIDTH*PW-1:0] alloc_preg,
    input  logic [WIDTH-1:0]    rel_en,
    input  logic [WIDTH*PW-1:0] rel_preg,
    input  logic                ckpt_en,
    output logic                ckpt_ready,
    output logic [CW-1:0]       ckpt_id,
    input  logic                ckpt_commit,
    input  logic                rec_en,
    input  logic [CW-1:0]       rec_id,
    output logic [PW:0]         free_count,
    output logic                overflow_err
);
    localparam int D    = P_REGISTERS - L_REGISTERS;
    localparam int PTRW = $clog2(2 * D);
    localparam int IW   = (D > 1) ? $clog2(D) : 1;
    localparam int NW   = $clog2(C_NUM + 1);

    typedef logic [PTRW-1:0] ptr_t;
    typedef logic [PW:0]     cnt_t;
    typedef logic [NW-1:0]   ccnt_t;

    // Pointers run 0..2D-1; the upper half is the second lap.
    function automatic ptr_t ptr_add(input ptr_t p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= 2 * D) s = s - 2 * D;
        return ptr_t'(s);
    endfunction

    function automatic logic [IW-1:0] ptr_idx(input ptr_t p);
        int s;
        s = int'(p);
        if (s >= D) s = s - D;
        return IW'(s);
    endfunction

    function automatic int ptr_dist(input ptr_t a, input ptr_t b);
        int s;
        s = int'(a) - int'(b);
        if (s < 0) s = s + 2 * D;
        return s;
    endfunction

    logic [PW-1:0] entry_q [D];
    logic [PW-1:0] entry_d [D];
    ptr_t          saved_q [C_NUM];
    ptr_t          saved_d [C_NUM];
    ptr_t          head_q, head_d;
    ptr_t          tail_q, tail_d;
    cnt_t          count_q, count_d;
    logic [CW-1:0] cid_q, cid_d;
    ccnt_t         ccnt_q, ccnt_d;
    logic          ovf_q, ovf_d;

    int n_req, n_rel, n_alloc, base, k, cnt_c, old_i, new_i;

    assign free_count   = count_q;
    assign overflow_err = ovf_q;
    assign ckpt_id      = cid_q;
    assign ckpt_ready   = int'(ccnt_q) < C_NUM;
    assign alloc_ready  = !rec_en && (int'(count_q) >= WIDTH);

    // Next-state: alloc/recover the head, then apply releases at the tail.
    always_comb begin
        n_req = 0;
        n_rel = 0;
        for (int i = 0; i < WIDTH; i++) begin
            alloc_preg[i*PW +: PW] = entry_q[ptr_idx(ptr_add(head_q, n_req))];
            if (alloc_req[i]) n_req = n_req + 1;
            if (rel_en[i]) n_rel = n_rel + 1;
        end
        n_alloc = alloc_ready ? n_req : 0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        entry_d = entry_q;
        saved_d = saved_q;
        cid_d   = cid_q;
        ccnt_d  = ccnt_q;
        ovf_d   = ovf_q;
        old_i   = 0;
        new_i   = 0;
        k       = 0;
        cnt_c   = int'(ccnt_q);
        if (ckpt_commit && cnt_c != 0) cnt_c = cnt_c - 1;
        if (rec_en) begin
            base   = int'(count_q) + ptr_dist(head_q, saved_q[rec_id]);
            head_d = saved_q[rec_id];
            old_i  = int'(cid_q) - cnt_c;
            if (old_i < 0) old_i = old_i + C_NUM;
            new_i  = int'(rec_id) - old_i;
            if (new_i < 0) new_i = new_i + C_NUM;
            ccnt_d = ccnt_t'(new_i);
            cid_d  = rec_id;
        end else begin
            base   = int'(count_q) - n_alloc;
            head_d = ptr_add(head_q, n_alloc);
            if (ckpt_en && ckpt_ready) begin
                saved_d[cid_q] = head_d;
                cid_d = (int'(cid_q) == C_NUM - 1) ? '0 : cid_q + 1'b1;
                cnt_c = cnt_c + 1;
            end
            ccnt_d = ccnt_t'(cnt_c);
        end
        if (base + n_rel > D) begin
            ovf_d   = 1'b1;
            count_d = cnt_t'(base);
        end else begin
            count_d = cnt_t'(base + n_rel);
            tail_d  = ptr_add(tail_q, n_rel);
            for (int i = 0; i < WIDTH; i++) begin
                if (rel_en[i]) begin
                    entry_d[ptr_idx(ptr_add(tail_q, k))] = rel_preg[i*PW +: PW];
                    k = k + 1;
                end
            end
        end
    end

    // State registers; reset loads the non-architectural P-regs in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) entry_q[i] <= PW'(L_REGISTERS + i);
            for (int i = 0; i < C_NUM; i++) saved_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= cnt_t'(D);
            cid_q   <= '0;
            ccnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            saved_q <= saved_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cid_q   <= cid_d;
            ccnt_q  <= ccnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
